// File: rtl/tx_port_arbiter_pkg.sv
// Shared definitions for the router output-port arbitration logic.
// Holds the default flit width, the router port count, symbolic port
// indices, the arbiter FSM state encoding and a wrap-around index helper.
package tx_port_arbiter_pkg;

  localparam int SIZE_DEF = 8;
  localparam int N_PORTS  = 5;

  // Router port indices
  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } arb_state_e;

  // Next index after idx in a ring of n entries
  function automatic int next_index(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tx_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans pending starting at ptr, wrapping from N_REQ-1 back to 0, and
// returns the first pending index.
// Ports:
//   pending  in  N_REQ  request-pending flags
//   ptr      in  GW     highest-priority index (must be < N_REQ)
//   any      out 1      at least one request pending
//   idx      out GW     selected index (0 when nothing pending)
module rr_pick
  import tx_port_arbiter_pkg::*;
#(
  parameter int N_REQ = N_PORTS,
  parameter int GW    = 3
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [GW-1:0]    ptr,
  output logic             any,
  output logic [GW-1:0]    idx
);

  localparam logic [GW:0] NR = (GW+1)'(N_REQ);

  // Walk from the farthest offset down to offset 0 so the candidate
  // closest to ptr overwrites any earlier match.
  always_comb begin
    logic [GW:0] cand;
    cand = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (GW+1)'(k);
      if (cand >= NR) cand = cand - NR;
      if (pending[cand[GW-1:0]]) begin
        any = 1'b1;
        idx = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_port_arbiter.sv
// Round-robin arbiter sharing one 2-phase transceiver channel between
// N_REQ 2-phase requesters. A requester posts a transfer by toggling its
// in_req bit; the winner's data is driven on out_data with an out_req
// toggle, and once the (synchronised) out_ack toggle matches, the
// requester's in_ack bit is toggled back.
// Ports:
//   clk, reset  clock / asynchronous active-high reset
//   in_req      per-requester request toggles
//   in_data     requester i data at [SIZE*i +: SIZE]
//   in_ack      per-requester ack toggles
//   out_req     request toggle toward the transceiver
//   out_ack     ack toggle from the transceiver (may be asynchronous)
//   out_data    data for the transceiver, held until ack
//   busy        transfer outstanding
//   grant       requester being served (valid when busy)
//   proto_err   sticky: transceiver ack toggled while idle
module tx_port_arbiter
  import tx_port_arbiter_pkg::*;
#(
  parameter int SIZE        = SIZE_DEF,
  parameter int N_REQ       = N_PORTS,
  parameter int GW          = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      in_req,
  input  logic [N_REQ*SIZE-1:0] in_data,
  output logic [N_REQ-1:0]      in_ack,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic [SIZE-1:0]       out_data,
  output logic                  busy,
  output logic [GW-1:0]         grant,
  output logic                  proto_err
);

  arb_state_e             state;
  logic [GW-1:0]          rr_ptr;
  logic [SYNC_STAGES-1:0] ack_pipe;
  logic                   ack_sync;
  logic                   ack_prev;
  logic [N_REQ-1:0]       pending;
  logic                   pick_any;
  logic [GW-1:0]          pick_idx;

  assign pending  = in_req ^ in_ack;
  assign ack_sync = ack_pipe[SYNC_STAGES-1];

  rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr_pick (
    .pending (pending),
    .ptr     (rr_ptr),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      ack_pipe  <= '0;
      ack_prev  <= 1'b0;
      in_ack    <= '0;
      out_req   <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      grant     <= '0;
      proto_err <= 1'b0;
    end else begin
      // out_ack synchroniser; ack_prev tracks its output for change detection
      ack_pipe[0] <= out_ack;
      for (int i = 1; i < SYNC_STAGES; i++) ack_pipe[i] <= ack_pipe[i-1];
      ack_prev <= ack_sync;

      case (state)
        IDLE: begin
          // The transceiver has nothing to acknowledge while idle
          if (ack_sync != ack_prev) proto_err <= 1'b1;
          if (pick_any) begin
            out_data <= in_data[int'(pick_idx)*SIZE +: SIZE];
            out_req  <= ~out_req;
            grant    <= pick_idx;
            busy     <= 1'b1;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_sync == out_req) begin
            in_ack[grant] <= ~in_ack[grant];
            busy          <= 1'b0;
            rr_ptr        <= GW'(next_index(int'(grant), N_REQ));
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_port_arbiter.sv
module tb_tx_port_arbiter;

  localparam int SIZE  = 8;
  localparam int N_REQ = 5;
  localparam int GW    = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_REQ-1:0]      in_req;
  logic [N_REQ*SIZE-1:0] in_data;
  logic [N_REQ-1:0]      in_ack;
  logic                  out_req;
  logic                  out_ack;
  logic [SIZE-1:0]       out_data;
  logic                  busy;
  logic [GW-1:0]         grant;
  logic                  proto_err;

  int total = 0;
  int bad   = 0;
  logic [N_REQ-1:0] exp_in_ack;
  logic             exp_out_req;

  tx_port_arbiter #(
    .SIZE        (SIZE),
    .N_REQ       (N_REQ),
    .GW          (GW),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_req    (in_req),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_req   (out_req),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .busy      (busy),
    .grant     (grant),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] data_of(input int i);
    case (i)
      0: return 8'h11;
      1: return 8'h22;
      2: return 8'hA5;
      3: return 8'h3C;
      default: return 8'h4F;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset       = 1'b1;
    in_req      = '0;
    out_ack     = 1'b0;
    exp_in_ack  = '0;
    exp_out_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // One full transfer of requester g, which must already be pending.
  // Optionally toggles in_req[late] while the transfer is outstanding.
  task automatic serve(input string tag, input int g, input int late);
    logic [7:0] d;
    d = data_of(g);
    exp_out_req = ~exp_out_req;
    tick();
    total += 4;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_start: got %b want 1", tag, busy); end
    if (grant !== GW'(g)) begin bad++; $display("FAIL %s grant: got %0d want %0d", tag, grant, g); end
    if (out_data !== d) begin bad++; $display("FAIL %s out_data: got %h want %h", tag, out_data, d); end
    if (out_req !== exp_out_req) begin bad++; $display("FAIL %s out_req: got %b want %b", tag, out_req, exp_out_req); end
    if (late >= 0) in_req[late] = ~in_req[late];
    out_ack = exp_out_req;
    repeat (2) tick();
    total += 4;
    if (in_ack !== exp_in_ack) begin bad++; $display("FAIL %s in_ack_early: got %b want %b", tag, in_ack, exp_in_ack); end
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_hold: got %b want 1", tag, busy); end
    if (grant !== GW'(g)) begin bad++; $display("FAIL %s grant_hold: got %0d want %0d", tag, grant, g); end
    if (out_data !== d) begin bad++; $display("FAIL %s data_hold: got %h want %h", tag, out_data, d); end
    tick();
    exp_in_ack[g] = ~exp_in_ack[g];
    total += 3;
    if (in_ack !== exp_in_ack) begin bad++; $display("FAIL %s in_ack: got %b want %b", tag, in_ack, exp_in_ack); end
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_end: got %b want 0", tag, busy); end
    if (proto_err !== 1'b0) begin bad++; $display("FAIL %s proto_err: got %b want 0", tag, proto_err); end
  endtask

  task automatic test_reset;
    apply_reset();
    total += 6;
    if (in_ack !== '0) begin bad++; $display("FAIL reset in_ack: got %b want 0", in_ack); end
    if (out_req !== 1'b0) begin bad++; $display("FAIL reset out_req: got %b want 0", out_req); end
    if (out_data !== '0) begin bad++; $display("FAIL reset out_data: got %h want 0", out_data); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    if (grant !== '0) begin bad++; $display("FAIL reset grant: got %0d want 0", grant); end
    if (proto_err !== 1'b0) begin bad++; $display("FAIL reset proto_err: got %b want 0", proto_err); end
  endtask

  task automatic test_single;
    in_req[2] = ~in_req[2];
    serve("single", 2, -1);
  endtask

  task automatic test_round_robin;
    apply_reset();
    in_req = 5'b11111;
    for (int i = 0; i < N_REQ; i++) serve("rr_all", i, -1);
    in_req[0] = ~in_req[0];
    in_req[3] = ~in_req[3];
    serve("rr_again", 0, -1);
    serve("rr_again", 3, -1);
  endtask

  task automatic test_wrap;
    // pointer sits at 4 here
    in_req[1] = ~in_req[1];
    in_req[4] = ~in_req[4];
    serve("wrap", 4, -1);
    serve("wrap", 1, -1);
    // pointer must now be 2, so 2 beats 1
    in_req[1] = ~in_req[1];
    in_req[2] = ~in_req[2];
    serve("wrap_ptr", 2, -1);
    serve("wrap_ptr", 1, -1);
  endtask

  task automatic test_late_arrival;
    in_req[3] = ~in_req[3];
    serve("late", 3, 0);
    serve("late_next", 0, -1);
  endtask

  task automatic test_proto_err;
    out_ack = ~out_ack;
    repeat (4) tick();
    total += 3;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL perr set: got %b want 1", proto_err); end
    if (in_ack !== exp_in_ack) begin bad++; $display("FAIL perr in_ack: got %b want %b", in_ack, exp_in_ack); end
    if (busy !== 1'b0) begin bad++; $display("FAIL perr busy: got %b want 0", busy); end
    repeat (5) tick();
    total += 1;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL perr sticky: got %b want 1", proto_err); end
    apply_reset();
    total += 1;
    if (proto_err !== 1'b0) begin bad++; $display("FAIL perr cleared: got %b want 0", proto_err); end
  endtask

  task automatic test_reset_mid_op;
    in_req[1] = ~in_req[1];
    tick();
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL midrst busy_pre: got %b want 1", busy); end
    if (out_req !== 1'b1) begin bad++; $display("FAIL midrst out_req_pre: got %b want 1", out_req); end
    #2;
    reset = 1'b1;
    #1;
    total += 5;
    if (out_req !== 1'b0) begin bad++; $display("FAIL midrst out_req: got %b want 0", out_req); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst busy: got %b want 0", busy); end
    if (grant !== '0) begin bad++; $display("FAIL midrst grant: got %0d want 0", grant); end
    if (out_data !== '0) begin bad++; $display("FAIL midrst out_data: got %h want 0", out_data); end
    if (in_ack !== '0) begin bad++; $display("FAIL midrst in_ack: got %b want 0", in_ack); end
    in_req      = '0;
    out_ack     = 1'b0;
    exp_in_ack  = '0;
    exp_out_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    in_req[4] = ~in_req[4];
    serve("after_rst", 4, -1);
  endtask

  initial begin
    reset   = 1'b1;
    in_req  = '0;
    out_ack = 1'b0;
    in_data = {8'h4F, 8'h3C, 8'hA5, 8'h22, 8'h11};
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_late_arrival();
    test_proto_err();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
